// File: rtl/pc_flow_ctrl.sv
// PC/pipeline-register hazard controller: branch, load-use, imem wait, jump priority.
// Zero-latency combinational controls; stalls hold PC and IF/ID and bubble ID/EX.
module pc_flow_ctrl #(
    parameter int CNT_W        = 16,
    parameter int IMEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             imem_timeout
);

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;

    localparam int                WAIT_W   = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IMEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic [WAIT_W-1:0] imem_wait_q, imem_wait_d;
    logic              timeout_q, timeout_d;
    logic              load_use;
    logic              is_jump;
    logic              do_stall;
    logic              do_flush;

    // rs is always compared, so a JR waits for a load producing its target.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign is_jump  = id_jump || id_jr;

    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        do_stall    = 1'b0;
        do_flush    = 1'b0;
        state_d     = state_q;
        imem_wait_d = '0;
        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (ex_branch_taken) begin
                    pc_write    = 1'b1;
                    pc_src      = 2'b01;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    do_flush    = 1'b1;
                end else if (load_use || !imem_ready) begin
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    do_stall    = 1'b1;
                end else if (is_jump) begin
                    pc_write    = 1'b1;
                    pc_src      = 2'b10;
                    ifid_flush  = 1'b1;
                    do_flush    = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                end

                if (state_q == ST_RUN) begin
                    if (!imem_ready && !ex_branch_taken)
                        state_d = ST_WAIT;
                end else if (imem_ready) begin
                    state_d = ST_RUN;
                end

                if (!imem_ready)
                    imem_wait_d = (imem_wait_q == WAIT_MAX) ? imem_wait_q
                                                            : imem_wait_q + 1'b1;
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_d   = (do_stall && stall_q != CNT_MAX) ? stall_q + 1'b1 : stall_q;
        flush_d   = (do_flush && flush_q != CNT_MAX) ? flush_q + 1'b1 : flush_q;
        timeout_d = timeout_q || (imem_wait_d == WAIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            stall_q     <= '0;
            flush_q     <= '0;
            imem_wait_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            imem_wait_q <= imem_wait_d;
            timeout_q   <= timeout_d;
        end
    end

    assign state        = state_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;
    assign imem_timeout = timeout_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Table-driven bench for pc_flow_ctrl; a second instance with 2-bit counters checks saturation.
module tb_pc_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, id_jr, ex_mem_read, ex_branch_taken, imem_ready;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, imem_timeout;
    logic [1:0]  pc_src, state;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_imem_timeout;
    logic [1:0]  s_pc_src, s_state;
    logic [1:0]  s_stall_count, s_flush_count;

    logic [7:0] dut_out;
    assign dut_out = {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, state};

    always #5 clk = ~clk;

    pc_flow_ctrl #(.CNT_W(16), .IMEM_TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_jr(id_jr), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .state(state), .stall_count(stall_count),
        .flush_count(flush_count), .imem_timeout(imem_timeout)
    );

    pc_flow_ctrl #(.CNT_W(2), .IMEM_TIMEOUT(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_jr(id_jr), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .pc_write(s_pc_write), .pc_src(s_pc_src), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .state(s_state),
        .stall_count(s_stall_count), .flush_count(s_flush_count), .imem_timeout(s_imem_timeout)
    );

    // {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, state}
    localparam logic [7:0] INIT_O   = 8'b0_00_1_1_1_00;
    localparam logic [7:0] ADV_RUN  = 8'b1_00_1_0_0_01;
    localparam logic [7:0] ADV_WAIT = 8'b1_00_1_0_0_10;
    localparam logic [7:0] STL_RUN  = 8'b0_00_0_0_1_01;
    localparam logic [7:0] STL_WAIT = 8'b0_00_0_0_1_10;
    localparam logic [7:0] BR_RUN   = 8'b1_01_1_1_1_01;
    localparam logic [7:0] BR_WAIT  = 8'b1_01_1_1_1_10;
    localparam logic [7:0] JMP_RUN  = 8'b1_10_1_1_0_01;
    localparam logic [7:0] JMP_WAIT = 8'b1_10_1_1_0_10;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, ert;
        logic       ut, jmp, jr, mr, bt, rdy;
        logic [7:0] exp;
        int         stall, flush;
        logic       to, cto;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ut, input logic jmp, input logic jr, input logic mr,
                                input logic [4:0] ert, input logic bt, input logic rdy,
                                input logic [7:0] exp, input int stall, input int flush,
                                input logic to, input logic cto);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.ut = ut; v.jmp = jmp; v.jr = jr; v.mr = mr;
        v.ert = ert; v.bt = bt; v.rdy = rdy; v.exp = exp; v.stall = stall; v.flush = flush;
        v.to = to; v.cto = cto;
        return v;
    endfunction

    function automatic logic [1:0] sat2(input int x);
        return (x > 3) ? 2'd3 : 2'(x);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ut; id_jump = v.jmp; id_jr = v.jr;
        ex_mem_read = v.mr; ex_rt = v.ert; ex_branch_taken = v.bt; imem_ready = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        nvec++;
        if (dut_out !== e.exp) begin
            nerr++;
            $display("FAIL %s outputs: got %b want %b", e.name, dut_out, e.exp);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (stall_count !== 16'(e.stall) || flush_count !== 16'(e.flush) ||
            (e.cto && imem_timeout !== e.to)) begin
            nerr++;
            $display("FAIL %s counters: got stall=%0d flush=%0d to=%b want stall=%0d flush=%0d to=%b",
                     e.name, stall_count, flush_count, imem_timeout, e.stall, e.flush, e.to);
        end
        nvec++;
        if (s_stall_count !== sat2(e.stall) || s_flush_count !== sat2(e.flush)) begin
            nerr++;
            $display("FAIL %s saturating: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.name, s_stall_count, s_flush_count, sat2(e.stall), sat2(e.flush));
        end
    endtask

    task automatic check_reset(input string name);
        nvec++;
        if (dut_out !== INIT_O || stall_count !== 16'd0 || flush_count !== 16'd0 ||
            imem_timeout !== 1'b0 || s_stall_count !== 2'd0 || s_flush_count !== 2'd0) begin
            nerr++;
            $display("FAIL %s: got out=%b stall=%0d flush=%0d to=%b want out=%b stall=0 flush=0 to=0",
                     name, dut_out, stall_count, flush_count, imem_timeout, INIT_O);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jump = 1'b0; id_jr = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0; imem_ready = 1'b1;

        //          name          rs  rt  ut jmp jr mr ert bt rdy exp       st fl to cto
        tbl.push_back(mk("init",      0,  0, 0, 0, 0, 0, 0, 0, 1, INIT_O,   0, 0, 0, 1));
        tbl.push_back(mk("idle0",     0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_RUN,  0, 0, 0, 1));
        tbl.push_back(mk("idle1",     0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_RUN,  0, 0, 0, 1));
        tbl.push_back(mk("lu_rs",     8,  0, 0, 0, 0, 1, 8, 0, 1, STL_RUN,  1, 0, 0, 1));
        tbl.push_back(mk("lu_r0",     0,  0, 0, 0, 0, 1, 0, 0, 1, ADV_RUN,  1, 0, 0, 1));
        tbl.push_back(mk("lu_rt",     3,  9, 1, 0, 0, 1, 9, 0, 1, STL_RUN,  2, 0, 0, 1));
        tbl.push_back(mk("rt_unused", 3,  9, 0, 0, 0, 1, 9, 0, 1, ADV_RUN,  2, 0, 0, 1));
        tbl.push_back(mk("br_lu",     8,  0, 0, 0, 0, 1, 8, 1, 1, BR_RUN,   2, 1, 0, 1));
        tbl.push_back(mk("jr_lu",     8,  0, 0, 1, 1, 1, 8, 0, 1, STL_RUN,  3, 1, 0, 1));
        tbl.push_back(mk("jr_go",     8,  0, 0, 1, 1, 0, 8, 0, 1, JMP_RUN,  3, 2, 0, 1));
        tbl.push_back(mk("imem_lo1",  0,  0, 0, 0, 0, 0, 0, 0, 0, STL_RUN,  4, 2, 0, 1));
        tbl.push_back(mk("imem_lo2",  0,  0, 0, 0, 0, 0, 0, 0, 0, STL_WAIT, 5, 2, 0, 1));
        tbl.push_back(mk("imem_lo3",  0,  0, 0, 0, 0, 0, 0, 0, 0, STL_WAIT, 6, 2, 0, 1));
        tbl.push_back(mk("imem_back", 0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_WAIT, 6, 2, 0, 1));
        tbl.push_back(mk("j_nrdy",    0,  0, 0, 1, 0, 0, 0, 0, 0, STL_RUN,  7, 2, 0, 1));
        tbl.push_back(mk("br_wait",   0,  0, 0, 0, 0, 0, 0, 1, 0, BR_WAIT,  7, 3, 0, 1));
        tbl.push_back(mk("j_wait",    0,  0, 0, 1, 0, 0, 0, 0, 1, JMP_WAIT, 7, 4, 0, 1));
        tbl.push_back(mk("idle2",     0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_RUN,  7, 4, 0, 1));
        tbl.push_back(mk("br_nrdy",   0,  0, 0, 0, 0, 0, 0, 1, 0, BR_RUN,   7, 5, 0, 1));
        tbl.push_back(mk("stay_run",  0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_RUN,  7, 5, 0, 1));
        // Five consecutive imem-not-ready cycles with a threshold of four.
        tbl.push_back(mk("to_1",      0,  0, 0, 0, 0, 0, 0, 0, 0, STL_RUN,  8, 5, 0, 1));
        tbl.push_back(mk("to_2",      0,  0, 0, 0, 0, 0, 0, 0, 0, STL_WAIT, 9, 5, 0, 1));
        tbl.push_back(mk("to_3",      0,  0, 0, 0, 0, 0, 0, 0, 0, STL_WAIT, 10, 5, 0, 1));
        tbl.push_back(mk("to_4",      0,  0, 0, 0, 0, 0, 0, 0, 0, STL_WAIT, 11, 5, 0, 0));
        tbl.push_back(mk("to_5",      0,  0, 0, 0, 0, 0, 0, 0, 0, STL_WAIT, 12, 5, 1, 1));
        tbl.push_back(mk("to_sticky", 0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_WAIT, 12, 5, 1, 1));
        tbl.push_back(mk("to_hold",   0,  0, 0, 0, 0, 0, 0, 0, 1, ADV_RUN,  12, 5, 1, 1));
        tbl.push_back(mk("pre_rst",   0,  0, 0, 0, 0, 0, 0, 0, 0, STL_RUN,  13, 5, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Reset while waiting on imem: everything pending is discarded.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("reset_mid_wait");
        rst_n = 1'b1;
        apply(mk("reinit", 0, 0, 0, 0, 0, 0, 0, 0, 1, INIT_O,  0, 0, 0, 1));
        apply(mk("rerun",  0, 0, 0, 0, 0, 0, 0, 0, 1, ADV_RUN, 0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
